// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: definitions shared by the sequential multiplier files.
//   state_t               : controller states (S_IDLE, S_RUN)
//   SEQ_MUL_DEFAULT_WIDTH : default operand width
//   count_width()         : iteration counter width, clog2(WIDTH), at least 1
package seq_mul_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int SEQ_MUL_DEFAULT_WIDTH = 8;

  // Width of a counter that holds 0..w-1. It is never below 1 bit.
  function automatic int count_width(input int w);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_abs.sv
// seq_mul_abs: turns a W-bit two's-complement value into its magnitude,
// given the value's sign bit. The same block serves as a general conditional
// negator: y = neg ? -x : x.
// The most negative value -2^(W-1) maps to 2^(W-1), which is the correct
// magnitude when y is read as unsigned.
//   x   in  W  value
//   neg in  1  negate x (the sign bit when x is used as a two's-complement operand)
//   y   out W  magnitude / conditionally negated value
module seq_mul_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_mul.sv
// seq_mul: shift-add multiplier that handles one multiplier bit per clock.
// An accepted start is followed by WIDTH busy cycles. done then pulses for one
// cycle with the 2*WIDTH-bit product on p. p holds that product until the
// next done.
//
// Build option SEQ_MUL_SIGNED_EN adds port sgn. With sgn=1, a and b are
// two's complement: the core multiplies their magnitudes, and the result is
// negated on its way into p when the operand signs differ. Latency is the
// same in both builds.
//
// Ports:
//   clk        in  1        rising-edge clock
//   rst        in  1        synchronous active-high reset
//   start      in  1        request, sampled only while busy=0
//   a, b       in  WIDTH    operands, captured on the accepted start edge
//   sgn        in  1        (SEQ_MUL_SIGNED_EN only) operands are signed
//   busy       out 1        multiplication in progress
//   done       out 1        one-cycle pulse, p valid in the same cycle
//   p          out 2*WIDTH  product
//   dbg_state  out state_t  controller state, for observation only
//
// Handshake: start is sampled on a rising edge only when busy=0 (state
// S_IDLE). A start seen while busy=1 is dropped. An accepted start raises busy
// on that edge. busy and done are never high together. A start may be issued
// in the done cycle, and that start is accepted.
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output state_t             dbg_state
);

  localparam int CW = count_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t state, state_n;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;   // multiplicand, pre-shifted so it always equals a<<count
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  logic             load, step, finish, last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    sum, prod;

  assign last = (count == CW'(WIDTH - 1));

  // Accumulator value after the current iteration. In the last iteration
  // this is the full unsigned product.
  assign sum = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_MUL_SIGNED_EN
  logic a_neg, b_neg, neg_r;

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];

  seq_mul_abs #(.W(WIDTH)) u_abs_a (.x(a), .neg(a_neg), .y(a_mag));
  seq_mul_abs #(.W(WIDTH)) u_abs_b (.x(b), .neg(b_neg), .y(b_mag));

  // The result is negated on the path into p, so no extra cycle is needed.
  seq_mul_abs #(.W(PW)) u_neg (.x(sum), .neg(neg_r), .y(prod));

  always_ff @(posedge clk) begin
    if (rst)       neg_r <= 1'b0;
    else if (load) neg_r <= a_neg ^ b_neg;
  end
`else
  assign a_mag = a;
  assign b_mag = b;
  assign prod  = sum;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (last)  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath controls decoded from the state
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      S_IDLE: load = start;
      S_RUN: begin
        step   = 1'b1;
        finish = last;
      end
      default: ;
    endcase
  end

  // Datapath. Operand 0 still runs all WIDTH iterations.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      done   <= 1'b0;
      p      <= '0;
    end else begin
      done <= finish;
      if (load) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        count  <= '0;
      end else if (step) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
        if (finish) p <= prod;
      end
    end
  end

  assign busy      = (state == S_RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed test of seq_mul. It uses a WIDTH=3 instance for the
// exhaustive unsigned table and a WIDTH=8 instance for edge cases,
// back-to-back starts, start-while-busy, reset mid-operation and, when
// SEQ_MUL_SIGNED_EN is defined, signed operands.
module tb_seq_mul;
  import seq_mul_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic        start3 = 1'b0, start8 = 1'b0;
  logic [2:0]  a3 = '0, b3 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy3, done3, busy8, done8;
  logic [5:0]  p3;
  logic [15:0] p8;
  state_t      st3, st8;
`ifdef SEQ_MUL_SIGNED_EN
  logic        sgn3 = 1'b0, sgn8 = 1'b0;
`endif

  seq_mul #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
`ifdef SEQ_MUL_SIGNED_EN
    .sgn(sgn3),
`endif
    .busy(busy3), .done(done3), .p(p3), .dbg_state(st3)
  );

  seq_mul #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef SEQ_MUL_SIGNED_EN
    .sgn(sgn8),
`endif
    .busy(busy8), .done(done8), .p(p8), .dbg_state(st8)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic get_busy(input int w);
    return (w == 3) ? busy3 : busy8;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 3) ? done3 : done8;
  endfunction

  function automatic logic [15:0] get_p(input int w);
    return (w == 3) ? 16'(p3) : p8;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents operands with start for one edge (the start edge E0). Returns
  // #1 after E0 with start low and the operand inputs scrambled.
  task automatic issue(input int w, input logic [7:0] av, input logic [7:0] bv);
    if (w == 3) begin
      a3 = av[2:0]; b3 = bv[2:0]; start3 = 1'b1;
    end else begin
      a8 = av; b8 = bv; start8 = 1'b1;
    end
    @(posedge clk); #1;
    start3 = 1'b0;
    start8 = 1'b0;
    a3 = 3'($urandom_range(0, 7));
    b3 = 3'($urandom_range(0, 7));
    a8 = 8'($urandom_range(0, 255));
    b8 = 8'($urandom_range(0, 255));
  endtask

  // Called #1 after E0. Waits a bounded number of cycles for done and checks
  // the latency, busy length and product against the head of exp_q. When
  // poke>0, a start with other operands is driven into WIDTH=8 during busy
  // iteration 'poke'. Returns #1 after the done edge.
  task automatic wait_result(input int w, input string name, input int poke);
    int          busy_cnt, lat;
    logic        got;
    logic [15:0] pv, expp;
    expp     = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    busy_cnt = get_busy(w) ? 1 : 0;
    got      = 1'b0;
    lat      = 0;
    pv       = '0;
    for (int k = 1; k <= w + 4 && !got; k++) begin
      if (poke > 0) begin
        if (k == poke) begin
          a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
        end else begin
          start8 = 1'b0;
        end
      end
      @(posedge clk); #1;
      if (get_done(w)) begin
        got = 1'b1; lat = k; pv = get_p(w);
      end else if (get_busy(w)) begin
        busy_cnt++;
      end
    end
    start8 = 1'b0;
    check({name, " done_seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(w));
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(w));
    check({name, " p"}, 32'(pv), 32'(expp));
    check({name, " busy_at_done"}, 32'(get_busy(w)), 32'd0);
  endtask

  // One full operation. Also checks that done is a single-cycle pulse and
  // that p holds afterwards.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] expp, input string name);
    exp_q.push_back(expp);
    issue(w, av, bv);
    wait_result(w, name, 0);
    @(posedge clk); #1;
    check({name, " done_pulse"}, 32'(get_done(w)), 32'd0);
    check({name, " p_held"}, 32'(get_p(w)), 32'(expp));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          w;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int w, input int a, input int b, input int p);
    vec_t v;
    v.w = w; v.a = 8'(a); v.b = 8'(b); v.p = 16'(p);
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n_done;

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        vecs.push_back(mk(3, i, j, i * j));
    vecs.push_back(mk(8, 255, 255, 65025));
    vecs.push_back(mk(8, 0, 200, 0));
    vecs.push_back(mk(8, 1, 1, 1));
    vecs.push_back(mk(8, 200, 0, 0));
    vecs.push_back(mk(8, 16, 16, 256));
    vecs.push_back(mk(8, 170, 85, 14450));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst busy8", 32'(busy8), 32'd0);
    check("rst done8", 32'(done8), 32'd0);
    check("rst p8", 32'(p8), 32'd0);
    check("rst state8", 32'(st8), 32'(S_IDLE));
    check("rst busy3", 32'(busy3), 32'd0);
    check("rst p3", 32'(p3), 32'd0);
    check("rst state3", 32'(st3), 32'(S_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    foreach (vecs[i])
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].p,
             $sformatf("w%0d %0d*%0d", vecs[i].w, vecs[i].a, vecs[i].b));

    // Start in the done cycle: 7*9 followed immediately by 12*10
    exp_q.push_back(16'd63);
    issue(8, 8'd7, 8'd9);
    wait_result(8, "b2b first", 0);
    exp_q.push_back(16'd120);
    issue(8, 8'd12, 8'd10);
    check("b2b done_pulse", 32'(done8), 32'd0);
    check("b2b busy_restart", 32'(busy8), 32'd1);
    check("b2b p_held", 32'(p8), 32'd63);
    wait_result(8, "b2b second", 0);

    // Start pulsed while busy must be ignored
    @(posedge clk); #1;
    exp_q.push_back(16'd143);
    issue(8, 8'd13, 8'd11);
    wait_result(8, "busy_ignore", 3);
    @(posedge clk); #1;
    check("busy_ignore no_restart", 32'(busy8), 32'd0);
    check("busy_ignore no_done", 32'(done8), 32'd0);
    check("busy_ignore p_held", 32'(p8), 32'd143);

    // Reset during busy cycle 4 of 8
    issue(8, 8'd100, 8'd100);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("midrst busy_before", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst busy", 32'(busy8), 32'd0);
    check("midrst p", 32'(p8), 32'd0);
    check("midrst done", 32'(done8), 32'd0);
    check("midrst state", 32'(st8), 32'(S_IDLE));
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) n_done++;
    end
    check("midrst no_done_after", 32'(n_done), 32'd0);
    run_op(8, 8'd5, 8'd6, 16'd30, "after_rst 5*6");

`ifdef SEQ_MUL_SIGNED_EN
    sgn8 = 1'b1;
    run_op(8, 8'h80, 8'h80, 16'd16384, "s -128*-128");
    run_op(8, 8'hFD, 8'd7, 16'hFFEB, "s -3*7");
    run_op(8, 8'd127, 8'hFF, 16'hFF81, "s 127*-1");
    run_op(8, 8'hFF, 8'hFF, 16'd1, "s -1*-1");
    sgn8 = 1'b0;
    run_op(8, 8'h80, 8'h80, 16'd16384, "u 0x80*0x80");
    run_op(8, 8'hFD, 8'd7, 16'd1771, "u 253*7");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised sequential shift-add multiplier, the multi-cycle successor to the fixed 3-bit combinational multiplier. It accepts two WIDTH-bit operands on a start pulse and iterates one partial product per clock. It returns a 2*WIDTH-bit product with a one-cycle done pulse. It sits in datapaths where area matters more than single-cycle latency.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  multiplicand; captured on the accepted start edge.
- b  in  WIDTH  multiplier; captured on the accepted start edge.
- sgn  in  1  present only with SEQ_MUL_SIGNED_EN; 1 means a and b are two's complement; captured with a and b.
- busy  out  1  high while a multiplication is in progress.
- done  out  1  one-cycle pulse; p is valid in the same cycle.
- p  out  2*WIDTH  product; held until the next done.

## Operation
- FSM states:
  - IDLE: start=1 captures operands, clears the accumulator, sets count=0, moves to RUN, busy<=1.
  - RUN: each cycle, if multiplier LSB=1, accumulator += multiplicand<<count; multiplier>>=1; count++.
  - RUN exit: on the iteration where count reaches WIDTH-1, write p, set done<=1 and busy<=0, return to IDLE.
- Arithmetic: the accumulator is 2*WIDTH bits and cannot overflow, since (2^W-1)^2 < 2^(2W).
- start while busy=1 is ignored with no effect. Callers must wait for done.
- start in the cycle done=1 is legal and accepted. Back-to-back throughput is one result per WIDTH cycles.
- Operands may change freely after capture.
- Outputs after reset: busy=0, done=0, p=0.
- Reset mid-operation aborts the operation and returns to IDLE with the reset values. No done is issued for the aborted operation.
- Operand 0 still takes the full WIDTH cycles. There is no early termination.

## Timing
- The start edge is E0. busy is high for cycles E0+1..E0+WIDTH.
- done is high for exactly one cycle after edge E0+WIDTH, so latency is WIDTH cycles.
- p updates only on the done edge and is stable between done pulses.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- SEQ_MUL_SIGNED_EN defined:
  - Port sgn exists.
  - With sgn=1, absolute values of a and b are captured and the unsigned core runs.
  - The final product is negated when the operand signs differ. Negation is combinational into the p register, so there is no extra cycle.
  - -2^(WIDTH-1) is handled: its magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits.
  - sgn=0 gives unsigned behaviour.
- SEQ_MUL_SIGNED_EN undefined: sgn is absent, multiplication is unsigned only, and there is no sign logic.
- Latency is identical in both builds.

## Structure
- Shared package seq_mul_pkg holds:
  - the state typedef (S_IDLE, S_RUN);
  - the constant SEQ_MUL_DEFAULT_WIDTH=8;
  - a count-width function, clog2(WIDTH).
- One sub-module, seq_mul_abs (WIDTH-bit two's-complement to magnitude plus sign bit), instantiated twice.
  - Instantiate it only under SEQ_MUL_SIGNED_EN.
  - Also reused for the conditional negation of the result.

## Test plan
- Exhaustive at WIDTH=3: all 64 (a,b) pairs, unsigned -> p=a*b, done exactly 3 cycles after start, busy high 3 cycles.
- Edge cases at WIDTH=8:
  - a=255, b=255 -> p=65025.
  - a=0, b=200 -> p=0 after 8 cycles.
  - a=1, b=1 -> p=1.
- start asserted in the done cycle with a=12, b=10 after a prior 7*9 -> p=63 then p=120, with no gap.
- start pulsed while busy with different operands -> ignored, and the original product is returned.
- Reset mid-operation: rst at cycle 4 of 8 -> busy=0, p=0, no done. A following start with a=5, b=6 -> p=30.
- With SEQ_MUL_SIGNED_EN, WIDTH=8, sgn=1:
  - -128*-128 -> 16384.
  - -3*7 -> 0xFFEB.
  - 127*-1 -> 0xFF81.
  - sgn=0 with a=b=0x80 -> 16384.
